// File: rtl/adpcm_out_pack.sv
// ADPCM output packer: packs 2..5-bit codewords LSB-first into bytes behind a small byte FIFO.
// Optional feature macro ADPCM_BYTE_CNT_EN adds a 16-bit popped-byte counter output.
module adpcm_out_pack #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_enable,
  input  logic                       test_mode,
  input  logic [1:0]                 rate,
  input  logic [4:0]                 code_in,
  input  logic                       code_valid,
  output logic                       code_ready,
  input  logic                       flush,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output logic [$clog2(DEPTH):0]     fifo_level
`ifdef ADPCM_BYTE_CNT_EN
  ,
  output logic [15:0]                byte_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [11:0]   acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  logic [3:0]    width_s;
  logic [4:0]    code_mask_s;
  logic [11:0]   code_ext_s;
  logic [7:0]    pad_mask_s;
  logic [7:0]    push_byte_s;
  logic          full_s, accept_s, norm_push_s, flush_push_s, flush_done_s;
  logic          push_s, pop_s;
  logic          unused_dft_s;

  // DFT hooks are intentionally not part of the datapath.
  assign unused_dft_s = scan_enable ^ test_mode;

  // Code width and mask decode from the rate select.
  always_comb begin
    case (rate)
      2'b00:   code_mask_s = 5'h03;
      2'b01:   code_mask_s = 5'h07;
      2'b10:   code_mask_s = 5'h0F;
      2'b11:   code_mask_s = 5'h1F;
      default: code_mask_s = 5'h03;
    endcase
    width_s    = {2'b00, rate} + 4'd2;
    code_ext_s = {7'd0, code_in & code_mask_s};
  end

  // Handshakes, push sources and flush sequencing.
  always_comb begin
    full_s       = (level_q == LW'(DEPTH));
    byte_valid   = (level_q != '0);
    code_ready   = !flush_pend_q && ((cnt_q < 4'd8) || !full_s);
    accept_s     = code_valid && code_ready;
    pop_s        = byte_valid && byte_ready;
    norm_push_s  = (cnt_q >= 4'd8) && !full_s;
    // Residual flush only once all whole bytes have drained into the FIFO.
    flush_push_s = flush_pend_q && (cnt_q != 4'd0) && (cnt_q < 4'd8) && !full_s;
    flush_done_s = flush_pend_q && ((cnt_q == 4'd0) || flush_push_s);
    push_s       = norm_push_s || flush_push_s;
    if (flush_pend_q) begin
      flush_pend_d = !flush_done_s;
    end else begin
      flush_pend_d = flush;
    end
  end

  // Accumulator update: shift out a full byte first, then insert the new code.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pad_mask_s  = 8'hFF >> (4'd8 - cnt_q);
    push_byte_s = acc_q[7:0];
    if (norm_push_s) begin
      acc_d = {8'h00, acc_q[11:8]};
      cnt_d = cnt_q - 4'd8;
    end else if (flush_push_s) begin
      push_byte_s = acc_q[7:0] & pad_mask_s;
      acc_d       = 12'h000;
      cnt_d       = 4'd0;
    end else begin
      acc_d = acc_q;
    end
    if (accept_s) begin
      acc_d = acc_d | (code_ext_s << cnt_d);
      cnt_d = cnt_d + width_s;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= 12'h000;
      cnt_q        <= 4'd0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // FIFO storage, pointers and level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_byte_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  assign byte_out   = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_level = level_q;

`ifdef ADPCM_BYTE_CNT_EN
  logic [15:0] byte_count_q;

  // Popped-byte counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count_q <= 16'h0000;
    end else if (pop_s) begin
      byte_count_q <= byte_count_q + 16'h0001;
    end else begin
      byte_count_q <= byte_count_q;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_adpcm_out_pack.sv
// Directed self-checking bench for adpcm_out_pack (DEPTH=4).
module tb_adpcm_out_pack;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_enable, test_mode;
  logic [1:0] rate;
  logic [4:0] code_in;
  logic       code_valid, code_ready, flush;
  logic [7:0] byte_out;
  logic       byte_valid, byte_ready;
  logic [2:0] fifo_level;
`ifdef ADPCM_BYTE_CNT_EN
  logic [15:0] byte_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  adpcm_out_pack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .scan_enable(scan_enable), .test_mode(test_mode),
    .rate(rate), .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .flush(flush), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_level(fifo_level)
`ifdef ADPCM_BYTE_CNT_EN
    , .byte_count(byte_count)
`endif
  );

  // Record every byte the consumer takes at the following rising edge.
  always @(negedge clk) begin
    if (!reset && byte_valid && byte_ready) got_q.push_back(byte_out);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] c);
    int budget;
    budget = 0;
    while (!code_ready && budget < 50) begin
      cycles(1);
      budget++;
    end
    if (!code_ready) begin
      check_val("send_timeout", 32'd0, 32'd1);
    end else begin
      code_in    = c;
      code_valid = 1'b1;
      cycles(1);
      code_valid = 1'b0;
      code_in    = 5'd0;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] exp[$]);
    check_val({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      check_val($sformatf("%s_byte%0d", tag, i), got_q[i], exp[i]);
    end
    got_q.delete();
  endtask

  initial begin
    reset = 1'b1; scan_enable = 1'b0; test_mode = 1'b0;
    rate = 2'b10; code_in = 5'd0; code_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1;
    #12;
    check_val("rst_byte_valid", byte_valid, 1'b0);
    check_val("rst_byte_out", byte_out, 8'h00);
    check_val("rst_level", fifo_level, 3'd0);
    check_val("rst_code_ready", code_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(1);

    // 4-bit codes form one byte
    rate = 2'b10;
    send(5'h03); send(5'h0A);
    cycles(4);
    expect_bytes("r4", '{8'hA3});
    check_val("r4_level", fifo_level, 3'd0);

    // 5-bit codes with flushed residual
    rate = 2'b11;
    send(5'h15); send(5'h0B);
    pulse_flush();
    cycles(5);
    expect_bytes("r5", '{8'h75, 8'h01});

    // 3-bit codes, one residual bit flushed
    rate = 2'b01;
    send(5'd7); send(5'd0); send(5'd5);
    pulse_flush();
    cycles(5);
    expect_bytes("r3", '{8'h47, 8'h01});

    // Fill FIFO with consumer stalled
    rate = 2'b10; byte_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(5'(i));
    check_val("full_level", fifo_level, 3'd4);
    check_val("full_code_ready", code_ready, 1'b0);
    check_val("full_head", byte_out, 8'h21);
    cycles(2);
    check_val("full_still_stalled", code_ready, 1'b0);
    byte_ready = 1'b1;
    cycles(8);
    expect_bytes("drain", '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9});
    check_val("drain_level", fifo_level, 3'd0);

    // Reset in the middle of a stream
    byte_ready = 1'b0;
    send(5'h3); send(5'h4); send(5'h5);
    cycles(1);
    check_val("pre_rst_level", fifo_level, 3'd1);
    #2 reset = 1'b1;
    #1;
    check_val("in_rst_byte_valid", byte_valid, 1'b0);
    check_val("in_rst_level", fifo_level, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    byte_ready = 1'b1;
    send(5'h0); send(5'h0);
    cycles(4);
    expect_bytes("post_rst", '{8'h00});

    // Latency, and flush with nothing pending
    byte_ready = 1'b0;
    send(5'h1); send(5'h2);
    check_val("lat_not_yet", byte_valid, 1'b0);
    cycles(1);
    check_val("lat_visible", byte_valid, 1'b1);
    check_val("lat_level", fifo_level, 3'd1);
    pulse_flush();
    cycles(4);
    check_val("flush0_level", fifo_level, 3'd1);
    check_val("flush0_head", byte_out, 8'h21);
    byte_ready = 1'b1;
    cycles(3);
    expect_bytes("flush0", '{8'h21});
`ifdef ADPCM_BYTE_CNT_EN
    check_val("bcnt_2", byte_count, 16'd2);
`endif
    send(5'hF); send(5'hF);
    cycles(4);
    expect_bytes("last", '{8'hFF});
`ifdef ADPCM_BYTE_CNT_EN
    check_val("bcnt_3", byte_count, 16'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
